// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop,
        StBreak
    } rx_state_e;

    localparam int unsigned MinDiv      = 4;
    localparam int unsigned DefDataBits = 8;

endpackage

// File: rtl/uart_sync.sv
// Metastability synchronizer: a Stages-deep flop chain that resets to 1 (line idle).
module uart_sync #(
    parameter int unsigned Stages = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [Stages-1:0] sync_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= '1;
        end else begin
            sync_q <= (sync_q << 1) | Stages'(d_i);
        end
    end

    assign q_o = sync_q[Stages-1];

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver: 16x-style mid-bit sampling with a one-entry holding register.
// Optional even-parity checking is compiled in with UART_RX_PARITY_EN.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS   = DefDataBits,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DIV_W       = 16
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    input  logic                 rx_i,
    input  logic [DIV_W-1:0]     clk_div_i,
    output logic [DATA_BITS-1:0] rx_data_o,
    output logic                 rx_valid_o,
    input  logic                 rx_ready_i,
    output logic                 frame_err_o,
    output logic                 overrun_o,
    output logic                 parity_err_o,
    output logic                 busy_o
);

    localparam int unsigned BitCntW = $clog2(DATA_BITS + 1);
    localparam int unsigned FlushW  = $clog2(SYNC_STAGES + 2);
    localparam logic [FlushW-1:0] FlushDone = FlushW'(SYNC_STAGES + 1);

    logic                 rx_s, rx_prev_q;
    logic [FlushW-1:0]    flush_q;
    rx_state_e            state_q, state_d;
    logic [DIV_W-1:0]     div_q, div_d, cnt_q, cnt_d, div_sel;
    logic [BitCntW-1:0]   bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d, data_q, data_d;
    logic                 valid_q, valid_d, frame_err_q, frame_err_d, overrun_q, overrun_d;
    logic                 fall, tick, deliver;
`ifdef UART_RX_PARITY_EN
    logic                 par_flag_q, par_flag_d, par_err_q, par_err_d;
`endif

    uart_sync #(
        .Stages (SYNC_STAGES)
    ) u_sync (
        .clk_i (wb_clk_i),
        .rst_i (wb_rst_i),
        .d_i   (rx_i),
        .q_o   (rx_s)
    );

    // Edges only count once the reset ones have drained out of the chain and rx_prev_q,
    // so a line held low through reset never looks like a start bit.
    assign fall    = (flush_q == FlushDone) && rx_prev_q && !rx_s;
    assign tick    = (cnt_q == DIV_W'(1));
    assign div_sel = (clk_div_i < DIV_W'(MinDiv)) ? DIV_W'(MinDiv) : clk_div_i;

    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        cnt_d       = (cnt_q != '0) ? cnt_q - DIV_W'(1) : cnt_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        frame_err_d = 1'b0;
        deliver     = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_flag_d  = par_flag_q;
        par_err_d   = 1'b0;
`endif
        case (state_q)
            StIdle: begin
                if (fall) begin
                    div_d   = div_sel;
                    cnt_d   = div_sel >> 1;
                    bit_d   = '0;
`ifdef UART_RX_PARITY_EN
                    par_flag_d = 1'b0;
`endif
                    state_d = StStart;
                end
            end
            StStart: begin
                if (tick) begin
                    cnt_d   = div_q;
                    state_d = rx_s ? StIdle : StData;
                end
            end
            StData: begin
                if (tick) begin
                    cnt_d   = div_q;
                    shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                    bit_d   = bit_q + BitCntW'(1);
                    if (bit_q == BitCntW'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                        state_d = StParity;
`else
                        state_d = StStop;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            StParity: begin
                if (tick) begin
                    cnt_d      = div_q;
                    par_flag_d = rx_s ^ (^shift_q);
                    state_d    = StStop;
                end
            end
`endif
            StStop: begin
                if (tick) begin
                    if (rx_s) begin
                        state_d = StIdle;
`ifdef UART_RX_PARITY_EN
                        if (par_flag_q) par_err_d = 1'b1;
                        else            deliver   = 1'b1;
`else
                        deliver = 1'b1;
`endif
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = StBreak;
                    end
                end
            end
            StBreak: begin
                if (rx_s) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Holding register: a delivery that meets an un-acknowledged byte is dropped.
    always_comb begin
        data_d    = data_q;
        valid_d   = valid_q;
        overrun_d = 1'b0;
        if (deliver) begin
            if (valid_q && !rx_ready_i) begin
                overrun_d = 1'b1;
            end else begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end
        end else if (valid_q && rx_ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            rx_prev_q   <= 1'b1;
            flush_q     <= '0;
            state_q     <= StIdle;
            div_q       <= '0;
            cnt_q       <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            rx_prev_q   <= rx_s;
            if (flush_q != FlushDone) flush_q <= flush_q + FlushW'(1);
            state_q     <= state_d;
            div_q       <= div_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            par_flag_q <= 1'b0;
            par_err_q  <= 1'b0;
        end else begin
            par_flag_q <= par_flag_d;
            par_err_q  <= par_err_d;
        end
    end

    assign parity_err_o = par_err_q;
`else
    assign parity_err_o = 1'b0;
`endif

    assign rx_data_o   = data_q;
    assign rx_valid_o  = valid_q;
    assign frame_err_o = frame_err_q;
    assign overrun_o   = overrun_q;
    assign busy_o      = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed self-checking bench for uart_rx_core (div=16, 8 data bits).
module tb_uart_rx_core;

    localparam int Div = 16;
`ifdef UART_RX_PARITY_EN
    localparam int RiseDelta = 171;
`else
    localparam int RiseDelta = 155;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        rx;
    logic [15:0] clk_div;
    logic [7:0]  rx_data;
    logic        rx_valid, rx_ready, frame_err, overrun, parity_err, busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int rise_cnt = 0, rise_cyc = 0, fe_cnt = 0, ov_cnt = 0, pe_cnt = 0;
    int start_cyc = 0;
    logic valid_prev = 1'b0;

    uart_rx_core dut (
        .wb_clk_i     (clk),
        .wb_rst_i     (rst),
        .rx_i         (rx),
        .clk_div_i    (clk_div),
        .rx_data_o    (rx_data),
        .rx_valid_o   (rx_valid),
        .rx_ready_i   (rx_ready),
        .frame_err_o  (frame_err),
        .overrun_o    (overrun),
        .parity_err_o (parity_err),
        .busy_o       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_valid === 1'b1 && valid_prev !== 1'b1) begin
            rise_cnt++;
            rise_cyc = cyc;
        end
        valid_prev = rx_valid;
        if (frame_err === 1'b1)  fe_cnt++;
        if (overrun === 1'b1)    ov_cnt++;
        if (parity_err === 1'b1) pe_cnt++;
    end

    task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_bad);
        start_cyc = cyc;
        rx = 1'b0;
        repeat (Div) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (Div) @(negedge clk);
        end
`ifdef UART_RX_PARITY_EN
        rx = (^d) ^ par_bad;
        repeat (Div) @(negedge clk);
`endif
        rx = stop_b;
        repeat (Div) @(negedge clk);
        rx = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic consume();
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", rx_valid); end
        total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h exp=00", rx_data); end
        total++; if ({frame_err, overrun, parity_err} !== 3'b000) begin
            bad++; $display("FAIL reset_pulses got=%b exp=000", {frame_err, overrun, parity_err});
        end
        // Line held low across reset must not start a frame.
        rx = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL low_after_reset_busy got=%b exp=0", busy); end
        rx = 1'b1;
        repeat (10) @(negedge clk);
        total++; if (rise_cnt !== 0) begin bad++; $display("FAIL low_after_reset_rise got=%0d exp=0", rise_cnt); end
    endtask

    task automatic test_basic();
        int r0 = rise_cnt, f0 = fe_cnt, o0 = ov_cnt, p0 = pe_cnt;
        fork
            send_frame(8'h55, 1'b1, 1'b0);
            begin
                repeat (40) @(negedge clk);
                clk_div = 16'd5;
            end
        join
        clk_div = 16'd16;
        total++; if (rise_cnt - r0 !== 1) begin bad++; $display("FAIL basic_rises got=%0d exp=1", rise_cnt - r0); end
        total++; if (rise_cyc - start_cyc !== RiseDelta) begin
            bad++; $display("FAIL basic_latency got=%0d exp=%0d", rise_cyc - start_cyc, RiseDelta);
        end
        total++; if (rx_data !== 8'h55) begin bad++; $display("FAIL basic_data got=%h exp=55", rx_data); end
        total++; if (fe_cnt + ov_cnt + pe_cnt - f0 - o0 - p0 !== 0) begin
            bad++; $display("FAIL basic_err_pulses got=%0d exp=0", fe_cnt + ov_cnt + pe_cnt - f0 - o0 - p0);
        end
        consume();
        total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL basic_consume got=%b exp=0", rx_valid); end
    endtask

    task automatic test_overrun();
        int o0 = ov_cnt;
        send_frame(8'hA3, 1'b1, 1'b0);
        send_frame(8'h0F, 1'b1, 1'b0);
        total++; if (rx_data !== 8'hA3) begin bad++; $display("FAIL overrun_data got=%h exp=a3", rx_data); end
        total++; if (rx_valid !== 1'b1) begin bad++; $display("FAIL overrun_valid got=%b exp=1", rx_valid); end
        total++; if (ov_cnt - o0 !== 1) begin bad++; $display("FAIL overrun_pulses got=%0d exp=1", ov_cnt - o0); end
        consume();
    endtask

    task automatic test_back_to_back();
        int o0 = ov_cnt;
        send_frame(8'hA3, 1'b1, 1'b0);
        fork
            send_frame(8'h0F, 1'b1, 1'b0);
            begin
                // Accept the old byte in the same cycle the new one is delivered.
                repeat (RiseDelta - 1) @(negedge clk);
                rx_ready = 1'b1;
                @(negedge clk);
                rx_ready = 1'b0;
            end
        join
        total++; if (rx_data !== 8'h0F) begin bad++; $display("FAIL b2b_data got=%h exp=0f", rx_data); end
        total++; if (rx_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid got=%b exp=1", rx_valid); end
        total++; if (ov_cnt - o0 !== 0) begin bad++; $display("FAIL b2b_overrun got=%0d exp=0", ov_cnt - o0); end
        consume();
    endtask

    task automatic test_glitch();
        int r0 = rise_cnt, f0 = fe_cnt, p0 = pe_cnt;
        rx = 1'b0;
        repeat (4) @(negedge clk);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL glitch_busy_start got=%b exp=1", busy); end
        repeat (2) @(negedge clk);
        rx = 1'b1;
        repeat (40) @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL glitch_idle got=%b exp=0", busy); end
        total++; if (rise_cnt - r0 + fe_cnt - f0 + pe_cnt - p0 !== 0) begin
            bad++; $display("FAIL glitch_outputs got=%0d exp=0", rise_cnt - r0 + fe_cnt - f0 + pe_cnt - p0);
        end
    endtask

    task automatic test_frame_err();
        int r0 = rise_cnt, f0 = fe_cnt;
        send_frame(8'h3C, 1'b0, 1'b0);
        repeat (10) @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL ferr_break_exit got=%b exp=0", busy); end
        send_frame(8'h81, 1'b1, 1'b0);
        total++; if (fe_cnt - f0 !== 1) begin bad++; $display("FAIL ferr_pulses got=%0d exp=1", fe_cnt - f0); end
        total++; if (rise_cnt - r0 !== 1) begin bad++; $display("FAIL ferr_rises got=%0d exp=1", rise_cnt - r0); end
        total++; if (rx_data !== 8'h81) begin bad++; $display("FAIL ferr_data got=%h exp=81", rx_data); end
        consume();
    endtask

    task automatic test_reset_mid();
        int r0 = rise_cnt;
        rx = 1'b0;
        repeat (Div + 30) @(negedge clk);
        rst = 1'b1;
        rx  = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
        repeat (20) @(negedge clk);
        send_frame(8'hE7, 1'b1, 1'b0);
        total++; if (rise_cnt - r0 !== 1) begin bad++; $display("FAIL rstmid_rises got=%0d exp=1", rise_cnt - r0); end
        total++; if (rx_data !== 8'hE7) begin bad++; $display("FAIL rstmid_data got=%h exp=e7", rx_data); end
        consume();
`ifdef UART_RX_PARITY_EN
        r0 = rise_cnt;
        begin
            int p0 = pe_cnt;
            send_frame(8'hE7, 1'b1, 1'b1);
            total++; if (pe_cnt - p0 !== 1) begin bad++; $display("FAIL parity_pulses got=%0d exp=1", pe_cnt - p0); end
            total++; if (rise_cnt - r0 !== 0) begin bad++; $display("FAIL parity_rises got=%0d exp=0", rise_cnt - r0); end
        end
`endif
    endtask

    initial begin
        rst      = 1'b1;
        rx       = 1'b1;
        rx_ready = 1'b0;
        clk_div  = 16'd16;
        @(negedge clk);
        test_reset();
        test_basic();
        test_overrun();
        test_back_to_back();
        test_glitch();
        test_frame_err();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_core.md
UART_RX_CORE -- requirements
Module: uart_rx_core

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, serial data bits per frame, LSB first.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, flops in the rx_i metastability synchronizer.
REQ-003 SHALL have parameter DIV_W, default 16, width of clk_div_i.
REQ-004 SHALL have port wb_clk_i  input  1  single clock; all logic is on its rising edge.
REQ-005 SHALL have port wb_rst_i  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port rx_i  input  1  asynchronous serial line, idle high.
REQ-007 SHALL have port clk_div_i  input  DIV_W  clocks per bit; legal values are 4 and above.
REQ-008 SHALL have port rx_data_o  output  DATA_BITS  received byte.
REQ-009 SHALL have port rx_valid_o  output  1  rx_data_o holds an unconsumed byte.
REQ-010 SHALL have port rx_ready_i  input  1  consumer accepts the byte when rx_valid_o is also high.
REQ-011 SHALL have port frame_err_o  output  1  one-cycle pulse, stop bit sampled low.
REQ-012 SHALL have port overrun_o  output  1  one-cycle pulse, new byte dropped because the holding register was full.
REQ-013 SHALL have port parity_err_o  output  1  one-cycle pulse, parity mismatch; tied 0 without UART_RX_PARITY_EN.
REQ-014 SHALL have port busy_o  output  1  high in every state except IDLE.

Function
REQ-015 SHALL run rx_i through SYNC_STAGES flops; all decisions use the synchronized value.
REQ-016 SHALL implement the states IDLE, START, DATA, PARITY, STOP, BREAK.
REQ-017 IDLE: a high-to-low transition on the synced line SHALL latch clk_div_i into an internal divisor, load the counter with divisor/2, and enter START.
REQ-018 START: on counter expiry, a low sample SHALL enter DATA with the counter set to the divisor; a high sample SHALL be treated as a glitch and return to IDLE with no output.
REQ-019 DATA: SHALL sample one bit per divisor clocks at mid-bit, shift it in LSB first, and leave after DATA_BITS samples for PARITY (macro defined) or STOP.
REQ-020 PARITY: SHALL sample one bit and compare it with even parity of the data; a mismatch SHALL set an internal flag.
REQ-021 STOP: a high sample SHALL deliver the byte and return to IDLE the next cycle.
REQ-022 STOP: a low sample SHALL pulse frame_err_o, discard the byte, and enter BREAK.
REQ-023 BREAK: SHALL stay until the synced line is high, then go to IDLE.
REQ-024 With the parity flag set, delivery SHALL be replaced by a parity_err_o pulse and the byte discarded; if the stop bit is also low, only frame_err_o SHALL pulse.
REQ-025 Delivery: rx_data_o and rx_valid_o=1 SHALL be registered one cycle after the stop-sample cycle.
REQ-026 rx_valid_o SHALL clear the cycle after rx_valid_o && rx_ready_i.
REQ-027 On delivery with rx_valid_o=1 and rx_ready_i=0, the old byte SHALL be kept, the new byte dropped, and overrun_o pulsed.
REQ-028 On delivery in the same cycle as a handshake, the new byte SHALL be loaded with rx_valid_o staying 1 and no overrun.
REQ-029 A change of clk_div_i mid-frame SHALL have no effect until the next start bit.

Reset
REQ-030 wb_rst_i high at a clock edge SHALL force the state to IDLE, the counter and shift register to 0, the synchronizer flops to 1, and rx_data_o to 0.
REQ-031 The same reset SHALL drive rx_valid_o, frame_err_o, overrun_o, parity_err_o and busy_o low, aborting any frame in progress.
REQ-032 After reset the block SHALL need a fresh falling edge; a line already low SHALL NOT start a frame.

Configuration
REQ-033 With macro UART_RX_PARITY_EN defined, the PARITY state and even-parity checking SHALL be compiled in (frame: start, DATA_BITS, parity, stop).
REQ-034 Without UART_RX_PARITY_EN, PARITY SHALL be absent, DATA SHALL go straight to STOP, and parity_err_o SHALL be constant 0.

Structure
REQ-035 A shared package uart_pkg SHALL hold the state enum typedef, the minimum divisor constant (4) and the default DATA_BITS.
REQ-036 One sub-module, uart_sync (an SYNC_STAGES-deep flop chain with reset value 1), SHALL be used; all other logic stays in uart_rx_core.

Verification
REQ-037 clk_div_i=16, frame 0x55 with valid stop -> rx_valid_o rises 1 cycle after the stop mid-sample, rx_data_o=0x55, no error pulses.
REQ-038 Frames 0xA3 then 0x0F with rx_ready_i=0 -> rx_data_o stays 0xA3 and overrun_o pulses once.
REQ-039 The same frames with rx_ready_i pulsed in the cycle the second byte is delivered -> rx_data_o=0x0F and no overrun.
REQ-040 A 6-cycle low glitch at div=16 -> return to IDLE, no rx_valid_o and no error pulses.
REQ-041 Frame 0x3C with stop bit low, then line high, then 0x81 -> frame_err_o pulses once and only 0x81 is delivered.
REQ-042 Reset asserted mid-DATA, then 0xE7 sent -> busy_o=0 after reset and 0xE7 received correctly; with UART_RX_PARITY_EN, a wrong parity on 0xE7 -> parity_err_o pulses and no rx_valid_o.
